emesh_mem_responder: RTL and testbench

//  Far-end emesh responder: consumes write and read request packets, as emitted by the elink
//  RX side or an AXI slave bridge, against a local word-addressed memory. Returns read-response
//  (rr) packets addressed back to the requester's srcaddr. Used as the chip-side memory model

---
 rtl/emesh_mem_responder_pkg.sv | 33 +++
 rtl/emesh_mem_ram.sv | 37 +++
 rtl/emesh_mem_responder.sv | 149 ++++++++++++++
 tb/tb_emesh_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emesh_mem_responder_pkg.sv
// Shared emesh packet layout, datamode encodings and responder state type.
// Packet: [0] write, [2:1] datamode, [7:3] ctrlmode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
package emesh_mem_responder_pkg;

    localparam int PKT_WRITE    = 0;
    localparam int PKT_DM_LSB   = 1;
    localparam int PKT_DM_W     = 2;
    localparam int PKT_CTRL_LSB = 3;
    localparam int PKT_CTRL_W   = 5;
    localparam int PKT_DST_LSB  = 8;
    localparam int PKT_DATA_LSB = 40;
    localparam int PKT_SRC_LSB  = 72;

    localparam logic [1:0] DM_BYTE   = 2'd0;
    localparam logic [1:0] DM_HALF   = 2'd1;
    localparam logic [1:0] DM_WORD   = 2'd2;
    localparam logic [1:0] DM_DOUBLE = 2'd3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } resp_state_t;

    // Lane-aligned byte enables; a double write only lands its low word.
    function automatic logic [3:0] byte_enables(input logic [1:0] dm, input logic [1:0] lsb);
        case (dm)
            DM_BYTE: return 4'b0001 << lsb;
            DM_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/emesh_mem_ram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables.
// Read data is registered and only updates on an enabled, non-writing cycle.
module emesh_mem_ram #(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [IW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_en && (i_we == 4'b0000)) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/emesh_mem_responder.sv
// Far-end emesh memory responder: clears its RAM after reset, then serves
// write requests and returns read responses to the requester's srcaddr.
module emesh_mem_responder
    import emesh_mem_responder_pkg::*;
#(
    parameter int          AW    = 32,
    parameter int          PW    = 2*AW+40,
    parameter logic [11:0] ID    = 12'h810,
    parameter int          DEPTH = 1024,
    parameter logic [31:0] BADRD = 32'hDEADBEEF
) (
    input  logic          sys_clk,
    input  logic          sys_nreset,
    input  logic          wr_access,
    input  logic [PW-1:0] wr_packet,
    output logic          wr_wait,
    input  logic          rd_access,
    input  logic [PW-1:0] rd_packet,
    output logic          rd_wait,
    output logic          rr_access,
    output logic [PW-1:0] rr_packet,
    input  logic          rr_wait,
    output logic          init_done,
    output logic [15:0]   drop_count,
    output resp_state_t   dbg_state
);

    localparam int IW = $clog2(DEPTH);

    resp_state_t           r_state, w_state_nxt;
    logic [IW-1:0]         r_init_idx;
    logic [15:0]           r_drop_count;
    logic                  r_rr_access, r_rr_write, r_rr_bad;
    logic [AW-1:0]         r_rr_dst;
    logic [PKT_CTRL_W-1:0] r_rr_ctrl;
    logic [PKT_DM_W-1:0]   r_rr_dm;

    logic [AW-1:0]         w_wr_dst, w_wr_data, w_rd_dst, w_rd_src, w_ram_q, w_rr_data;
    logic [PKT_DM_W-1:0]   w_wr_dm;
    logic                  w_run, w_wr_match, w_rd_match, w_wr_fire, w_rd_fire, w_rr_stall;
    logic                  w_ram_en;
    logic [3:0]            w_ram_we;
    logic [IW-1:0]         w_ram_addr;
    logic [31:0]           w_ram_wdata;
    logic                  w_unused;

    assign w_wr_dst  = wr_packet[PKT_DST_LSB  +: AW];
    assign w_wr_data = wr_packet[PKT_DATA_LSB +: AW];
    assign w_wr_dm   = wr_packet[PKT_DM_LSB   +: PKT_DM_W];
    assign w_rd_dst  = rd_packet[PKT_DST_LSB  +: AW];
    assign w_rd_src  = rd_packet[PKT_SRC_LSB  +: AW];
    assign w_unused  = ^{wr_packet, rd_packet};

    assign w_wr_match = (w_wr_dst[AW-1 -: 12] == ID);
    assign w_rd_match = (w_rd_dst[AW-1 -: 12] == ID);

    // Handshake: a request transfers on a cycle with access=1 and wait=0;
    // senders hold access/packet while wait=1. A stalled response blocks new reads.
    assign w_run      = (r_state == ST_RUN);
    assign w_rr_stall = r_rr_access & rr_wait;
    assign wr_wait    = ~w_run;
    assign rd_wait    = ~w_run | wr_access | w_rr_stall;
    assign w_wr_fire  = w_run & wr_access;
    assign w_rd_fire  = rd_access & ~rd_wait;

    always_ff @(posedge sys_clk or negedge sys_nreset) begin
        if (!sys_nreset) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_init_idx <= r_init_idx + IW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_init_idx == IW'(DEPTH-1)) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Single RAM port: clearing during INIT, otherwise a write wins over a read.
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 4'b0000;
        w_ram_addr  = r_init_idx;
        w_ram_wdata = '0;
        if (r_state == ST_INIT) begin
            w_ram_en = 1'b1;
            w_ram_we = 4'b1111;
        end else if (w_wr_fire) begin
            w_ram_en    = w_wr_match;
            w_ram_we    = w_wr_match ? byte_enables(w_wr_dm, w_wr_dst[1:0]) : 4'b0000;
            w_ram_addr  = w_wr_dst[IW+1:2];
            w_ram_wdata = w_wr_data;
        end else if (w_rd_fire) begin
            w_ram_en   = w_rd_match;
            w_ram_addr = w_rd_dst[IW+1:2];
        end
    end

    emesh_mem_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
        .i_clk   (sys_clk),
        .i_rst_n (sys_nreset),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge sys_clk or negedge sys_nreset) begin
        if (!sys_nreset) begin
            r_drop_count <= '0;
        end else if (w_wr_fire && !w_wr_match && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_nreset) begin
        if (!sys_nreset) begin
            r_rr_access <= 1'b0;
            r_rr_write  <= 1'b0;
            r_rr_bad    <= 1'b0;
            r_rr_dst    <= '0;
            r_rr_ctrl   <= '0;
            r_rr_dm     <= '0;
        end else if (w_rd_fire) begin
            r_rr_access <= 1'b1;
            r_rr_write  <= 1'b1;
            r_rr_bad    <= ~w_rd_match;
            r_rr_dst    <= w_rd_src;
            r_rr_ctrl   <= rd_packet[PKT_CTRL_LSB +: PKT_CTRL_W];
            r_rr_dm     <= rd_packet[PKT_DM_LSB +: PKT_DM_W];
        end else if (!w_rr_stall) begin
            r_rr_access <= 1'b0;
        end
    end

    assign w_rr_data  = r_rr_bad ? BADRD : w_ram_q;
    assign rr_access  = r_rr_access;
    assign rr_packet  = {{AW{1'b0}}, w_rr_data, r_rr_dst, r_rr_ctrl, r_rr_dm, r_rr_write};
    assign init_done  = w_run;
    assign drop_count = r_drop_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_emesh_mem_responder.sv
// Self-checking bench for emesh_mem_responder: reference memory model plus a
// response scoreboard drained by an independent monitor.
`timescale 1ns/1ps
module tb_emesh_mem_responder;
    import emesh_mem_responder_pkg::*;

    localparam int          AW    = 32;
    localparam int          PW    = 2*AW+40;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BADRD = 32'hDEADBEEF;

    logic          sys_clk = 1'b0;
    logic          sys_nreset;
    logic          wr_access, rd_access, rr_wait;
    logic [PW-1:0] wr_packet, rd_packet;
    logic          wr_wait, rd_wait, rr_access, init_done;
    logic [PW-1:0] rr_packet;
    logic [15:0]   drop_count;
    resp_state_t   dbg_state;

    int            checks = 0;
    int            errors = 0;
    int            n_resp = 0;
    int            rr_mode = 0;
    int            pat_cyc = 0;
    bit            rd_acc_pending = 1'b0;
    int            model_drops = 0;
    logic [31:0]   model_mem [DEPTH];
    logic [PW-1:0] exp_q [$];

    emesh_mem_responder dut (
        .sys_clk    (sys_clk),
        .sys_nreset (sys_nreset),
        .wr_access  (wr_access),
        .wr_packet  (wr_packet),
        .wr_wait    (wr_wait),
        .rd_access  (rd_access),
        .rd_packet  (rd_packet),
        .rd_wait    (rd_wait),
        .rr_access  (rr_access),
        .rr_packet  (rr_packet),
        .rr_wait    (rr_wait),
        .init_done  (init_done),
        .drop_count (drop_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers / reference model ----------------
    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk_pkt(input logic w, input logic [1:0] dm, input logic [4:0] ctrl,
                                             input logic [31:0] dst, input logic [31:0] data,
                                             input logic [31:0] src);
        return {src, data, dst, ctrl, dm, w};
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_drops = 0;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] dm);
        int idx, b, h;
        if (addr[31:20] != 12'h810) begin
            if (model_drops < 65535) model_drops++;
            return;
        end
        idx = int'(addr[11:2]);
        b   = int'(addr[1:0]);
        h   = int'(addr[1]);
        case (dm)
            2'd0:    model_mem[idx][8*b +: 8]   = data[8*b +: 8];
            2'd1:    model_mem[idx][16*h +: 16] = data[16*h +: 16];
            default: model_mem[idx]             = data;
        endcase
    endfunction

    function automatic logic [PW-1:0] model_rr(input logic [31:0] addr, input logic [31:0] src,
                                               input logic [1:0] dm, input logic [4:0] ctrl);
        logic [31:0] d;
        d = (addr[31:20] != 12'h810) ? BADRD : model_mem[int'(addr[11:2])];
        return {32'h0, d, src, ctrl, dm, 1'b1};
    endfunction

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] dm);
        bit ok = 1'b0;
        wr_packet = mk_pkt(1'b1, dm, 5'($urandom), addr, data, $urandom);
        wr_access = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge sys_clk);
            if (!wr_wait) begin ok = 1'b1; break; end
        end
        chk("wr_accept", ok, 1);
        @(posedge sys_clk);
        if (ok) model_write(addr, data, dm);
        #1 wr_access = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] src, input logic [1:0] dm,
                           input logic [4:0] ctrl);
        bit ok = 1'b0;
        rd_packet = mk_pkt(1'b0, dm, ctrl, addr, $urandom, src);
        rd_access = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge sys_clk);
            if (!rd_wait) begin ok = 1'b1; break; end
        end
        chk("rd_accept", ok, 1);
        @(posedge sys_clk);
        if (ok) exp_q.push_back(model_rr(addr, src, dm, ctrl));
        #1 rd_access = 1'b0;
        rd_acc_pending = ok;
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 0 && !rr_access) break;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic init_phase();
        int n = 0;
        @(negedge sys_clk);
        sys_nreset = 1'b1;
        for (int t = 0; t < DEPTH + 20; t++) begin
            @(negedge sys_clk);
            n++;
            if (!wr_wait) break;
            if (init_done || !rd_wait) chk("init_hold", {init_done, rd_wait}, 2'b01);
        end
        chk("init_cycles", n, DEPTH);
        chk("init_done", init_done, 1);
        chk("rd_wait_run", rd_wait, 0);
        @(posedge sys_clk);
        #1;
    endtask

    // ---------------- rr_wait generator ----------------
    initial begin
        rr_wait = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            pat_cyc++;
            case (rr_mode)
                1:       rr_wait = ($urandom_range(0, 2) == 0);
                2:       rr_wait = (pat_cyc >= 3 && pat_cyc <= 6);
                3:       rr_wait = 1'b1;
                default: rr_wait = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [PW-1:0] held;
        logic [PW-1:0] exp;
        bit stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge sys_clk);
            if (rd_acc_pending) begin
                chk("rr_latency", rr_access, 1);
                rd_acc_pending = 1'b0;
            end
            if (rr_access && rr_wait) begin
                if (stalled) chk("rr_stable", rr_packet, held);
                held    = rr_packet;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (rr_access && !rr_wait) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rr_unexpected: got %h, required no response", rr_packet);
                end else begin
                    exp = exp_q.pop_front();
                    chk("rr_packet", rr_packet, exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, d;
        logic [11:0] hi;
        int base;
        sys_nreset = 1'b0;
        wr_access  = 1'b0;
        rd_access  = 1'b0;
        wr_packet  = '0;
        rd_packet  = '0;
        clear_model();
        repeat (3) @(negedge sys_clk);
        chk("rst_wr_wait", wr_wait, 1);
        chk("rst_rd_wait", rd_wait, 1);
        chk("rst_rr_access", rr_access, 0);
        chk("rst_rr_packet", rr_packet, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_drop_count", drop_count, 0);
        init_phase();

        do_read(32'h81000010, 32'h8100F000, DM_WORD, 5'h0);
        do_write(32'h81000010, 32'h11223344, DM_WORD);
        do_read(32'h81000010, 32'h8100F000, DM_WORD, 5'h3);
        do_write(32'h81000011, 32'h0000AA00, DM_BYTE);
        do_read(32'h81000010, 32'h8100F004, DM_WORD, 5'h0);
        do_write(32'h81000012, 32'h55660000, DM_HALF);
        do_read(32'h81000010, 32'h8100F008, DM_HALF, 5'h1F);
        do_write(32'h81000020, 32'h0BADF00D, DM_DOUBLE);
        do_read(32'h81000020, 32'h8100F00C, DM_DOUBLE, 5'h5);
        drain();

        // Eight back-to-back reads with a stall window in the middle.
        for (int i = 0; i < 8; i++) do_write(32'h81000100 + 32'(4*i), $urandom, DM_WORD);
        base = n_resp;
        @(negedge sys_clk);
        pat_cyc = 0;
        rr_mode = 2;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 8; i++) do_read(32'h81000100 + 32'(4*i), 32'h8100F100 + 32'(i), DM_WORD, 5'(i));
        drain();
        chk("b2b_count", n_resp - base, 8);
        rr_mode = 0;

        // Simultaneous write and read: the write wins, the read sees its data.
        wr_packet = mk_pkt(1'b1, DM_WORD, 5'h0, 32'h81000030, 32'hCAFEF00D, 32'h0);
        wr_access = 1'b1;
        rd_packet = mk_pkt(1'b0, DM_WORD, 5'h2, 32'h81000030, 32'h0, 32'h8100F200);
        rd_access = 1'b1;
        @(negedge sys_clk);
        chk("same_cyc_rd_wait", rd_wait, 1);
        chk("same_cyc_wr_wait", wr_wait, 0);
        @(posedge sys_clk);
        model_write(32'h81000030, 32'hCAFEF00D, DM_WORD);
        #1 wr_access = 1'b0;
        @(negedge sys_clk);
        chk("same_cyc_rd_next", rd_wait, 0);
        @(posedge sys_clk);
        exp_q.push_back(model_rr(32'h81000030, 32'h8100F200, DM_WORD, 5'h2));
        #1 rd_access = 1'b0;
        rd_acc_pending = 1'b1;
        drain();

        // ID mismatch: write dropped and counted, read returns BADRD.
        do_write(32'h82000000, 32'h99999999, DM_WORD);
        @(negedge sys_clk);
        chk("drop_count_1", drop_count, 16'(model_drops));
        @(posedge sys_clk);
        #1;
        do_read(32'h82000000, 32'h8100F300, DM_WORD, 5'h0);
        do_read(32'h81000000, 32'h8100F304, DM_WORD, 5'h0);
        drain();

        // Randomized traffic with random response backpressure.
        rr_mode = 1;
        for (int i = 0; i < 300; i++) begin
            hi = ($urandom_range(0, 9) == 0) ? 12'h820 : 12'h810;
            a  = {hi, 8'($urandom), 10'($urandom_range(0, 15)), 2'($urandom)};
            d  = $urandom;
            if ($urandom_range(0, 1) == 0) do_write(a, d, 2'($urandom));
            else do_read(a, $urandom, 2'($urandom), 5'($urandom));
        end
        rr_mode = 0;
        drain();
        chk("drop_count_rand", drop_count, 16'(model_drops));

        // Reset while a response is held by backpressure.
        rr_mode = 3;
        do_read(32'h81000010, 32'h8100F400, DM_WORD, 5'h0);
        @(negedge sys_clk);
        #2 sys_nreset = 1'b0;
        #1;
        chk("mid_rst_rr_access", rr_access, 0);
        chk("mid_rst_rr_packet", rr_packet, 0);
        chk("mid_rst_wr_wait", wr_wait, 1);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_drop_count", drop_count, 0);
        exp_q.delete();
        clear_model();
        rr_mode = 0;
        init_phase();
        do_read(32'h81000010, 32'h8100F500, DM_WORD, 5'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
